// File: rtl/llc_set_read.sv
// -----------------------------------------------------------------------------
// llc_set_read
//
// Front stage of the LLC request pipeline, directly upstream of way lookup.
// A (set, tag) request is accepted against a credit that covers both the read
// in flight and the entries already buffered. Accepting a request issues the
// tag/state/evict SRAM read in the same cycle. The row returns one cycle later
// and is captured into a small FIFO that feeds the lookup stage.
//
// Writes from the update stage are folded into the data so the lookup stage
// never sees a stale row:
//   * A write in the accept cycle is not visible in the SRAM data, because the
//     SRAM reads before it writes. That write is held in wr_q and applied at
//     capture.
//   * A write in the capture cycle is applied on top of wr_q.
//   * A write while an entry sits in the FIFO patches that entry in place.
// An entry popped in the same cycle as a write does not see that write; the
// lookup stage resolves that case itself.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   req_*               request handshake (valid/ready) with set and tag
//   rd_en, rd_set       SRAM read command (combinational from accept)
//   rd_tags/states/evict_way  SRAM read data, valid the cycle after rd_en
//   wr_*                update-stage write (way tag/state, optional evict ptr)
//   out_*               FIFO head towards lookup (valid/ready), driven from
//                       storage registers only
// -----------------------------------------------------------------------------
module llc_set_read #(
    parameter int WAYS       = 16,
    parameter int WAY_BITS   = 4,
    parameter int TAG_BITS   = 16,
    parameter int SET_BITS   = 8,
    parameter int STATE_BITS = 3,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SET_BITS-1:0]          req_set,
    input  logic [TAG_BITS-1:0]          req_tag,
    output logic                         rd_en,
    output logic [SET_BITS-1:0]          rd_set,
    input  logic [WAYS*TAG_BITS-1:0]     rd_tags,
    input  logic [WAYS*STATE_BITS-1:0]   rd_states,
    input  logic [WAY_BITS-1:0]          rd_evict_way,
    input  logic                         wr_en,
    input  logic [SET_BITS-1:0]          wr_set,
    input  logic [WAY_BITS-1:0]          wr_way,
    input  logic [TAG_BITS-1:0]          wr_tag,
    input  logic [STATE_BITS-1:0]        wr_state,
    input  logic                         wr_evict_en,
    input  logic [WAY_BITS-1:0]          wr_evict_way,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SET_BITS-1:0]          out_set,
    output logic [TAG_BITS-1:0]          out_tag,
    output logic [WAYS*TAG_BITS-1:0]     out_tags,
    output logic [WAYS*STATE_BITS-1:0]   out_states,
    output logic [WAY_BITS-1:0]          out_evict_way
);

    localparam int TW = WAYS * TAG_BITS;
    localparam int SW = WAYS * STATE_BITS;
    localparam int CW = $clog2(DEPTH + 1);   // FIFO count width
    localparam int PW = $clog2(DEPTH);       // FIFO pointer width

    // -------------------------------------------------------------------------
    // Row patch helpers: replace one way's field inside a packed row
    // -------------------------------------------------------------------------
    function automatic logic [TW-1:0] put_tag(
        input logic [TW-1:0]       row,
        input logic [WAY_BITS-1:0] way,
        input logic [TAG_BITS-1:0] tag
    );
        logic [TW-1:0] res;
        res = row;
        res[way*TAG_BITS +: TAG_BITS] = tag;
        return res;
    endfunction

    function automatic logic [SW-1:0] put_state(
        input logic [SW-1:0]         row,
        input logic [WAY_BITS-1:0]   way,
        input logic [STATE_BITS-1:0] state
    );
        logic [SW-1:0] res;
        res = row;
        res[way*STATE_BITS +: STATE_BITS] = state;
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic                  r_inflight;
    logic [SET_BITS-1:0]   r_req_set;
    logic [TAG_BITS-1:0]   r_req_tag;

    // Write seen in the previous cycle (the accept cycle, at capture time)
    logic                  r_wq_en;
    logic [SET_BITS-1:0]   r_wq_set;
    logic [WAY_BITS-1:0]   r_wq_way;
    logic [TAG_BITS-1:0]   r_wq_tag;
    logic [STATE_BITS-1:0] r_wq_state;
    logic                  r_wq_evict_en;
    logic [WAY_BITS-1:0]   r_wq_evict_way;

    // Entry storage (not reset; only meaningful while counted as live)
    logic [SET_BITS-1:0]   r_ent_set    [DEPTH];
    logic [TAG_BITS-1:0]   r_ent_tag    [DEPTH];
    logic [TW-1:0]         r_ent_tags   [DEPTH];
    logic [SW-1:0]         r_ent_states [DEPTH];
    logic [WAY_BITS-1:0]   r_ent_evict  [DEPTH];

    // -------------------------------------------------------------------------
    // Combinational nets
    // -------------------------------------------------------------------------
    logic [CW:0]           w_occ;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_wq_hit;
    logic                  w_wr_hit;
    logic [TW-1:0]         w_st1_tags;
    logic [SW-1:0]         w_st1_states;
    logic [WAY_BITS-1:0]   w_st1_evict;
    logic [TW-1:0]         w_cap_tags;
    logic [SW-1:0]         w_cap_states;
    logic [WAY_BITS-1:0]   w_cap_evict;
    logic [DEPTH-1:0]      w_ent_live;
    logic [DEPTH-1:0]      w_ent_hit;

    // Credit and handshake decode. Credit looks only at registered occupancy,
    // so a pop returns its slot to the requester one cycle later.
    always_comb begin
        w_occ       = (CW+1)'(r_count) + (CW+1)'(r_inflight);
        w_req_ready = rst && (w_occ < (CW+1)'(DEPTH));
        w_accept    = req_valid && w_req_ready;
        w_out_valid = rst && (r_count != {CW{1'b0}});
        w_pop       = w_out_valid && out_ready;
        w_push      = r_inflight;
    end

    // Capture patching: previous-cycle write first, then this cycle's write,
    // so a same-way collision resolves to the newer write.
    always_comb begin
        w_wq_hit     = r_wq_en && (r_wq_set == r_req_set);
        w_wr_hit     = wr_en && (wr_set == r_req_set);

        w_st1_tags   = w_wq_hit ? put_tag(rd_tags, r_wq_way, r_wq_tag) : rd_tags;
        w_st1_states = w_wq_hit ? put_state(rd_states, r_wq_way, r_wq_state) : rd_states;
        w_st1_evict  = (w_wq_hit && r_wq_evict_en) ? r_wq_evict_way : rd_evict_way;

        w_cap_tags   = w_wr_hit ? put_tag(w_st1_tags, wr_way, wr_tag) : w_st1_tags;
        w_cap_states = w_wr_hit ? put_state(w_st1_states, wr_way, wr_state) : w_st1_states;
        w_cap_evict  = (w_wr_hit && wr_evict_en) ? wr_evict_way : w_st1_evict;
    end

    // Which storage slots hold live entries, and which of those the current
    // write targets. Distance from the read pointer wraps modulo DEPTH.
    always_comb begin
        w_ent_live = {DEPTH{1'b0}};
        w_ent_hit  = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_ent_live[i] = CW'(PW'(PW'(i) - r_rptr)) < r_count;
            w_ent_hit[i]  = w_ent_live[i] && wr_en && (r_ent_set[i] == wr_set);
        end
    end

    // Pointers, count, in-flight flag, request capture and wr_q
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count        <= {CW{1'b0}};
            r_wptr         <= {PW{1'b0}};
            r_rptr         <= {PW{1'b0}};
            r_inflight     <= 1'b0;
            r_req_set      <= {SET_BITS{1'b0}};
            r_req_tag      <= {TAG_BITS{1'b0}};
            r_wq_en        <= 1'b0;
            r_wq_set       <= {SET_BITS{1'b0}};
            r_wq_way       <= {WAY_BITS{1'b0}};
            r_wq_tag       <= {TAG_BITS{1'b0}};
            r_wq_state     <= {STATE_BITS{1'b0}};
            r_wq_evict_en  <= 1'b0;
            r_wq_evict_way <= {WAY_BITS{1'b0}};
        end else begin
            // At most one read outstanding at a time by construction.
            r_inflight <= w_accept;
            if (w_accept) begin
                r_req_set <= req_set;
                r_req_tag <= req_tag;
            end else begin
                r_req_set <= r_req_set;
                r_req_tag <= r_req_tag;
            end

            r_wq_en        <= wr_en;
            r_wq_set       <= wr_set;
            r_wq_way       <= wr_way;
            r_wq_tag       <= wr_tag;
            r_wq_state     <= wr_state;
            r_wq_evict_en  <= wr_evict_en;
            r_wq_evict_way <= wr_evict_way;

            if (w_push) begin
                r_wptr <= r_wptr + PW'(1'b1);
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1'b1);
            end else begin
                r_rptr <= r_rptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: capture into the tail slot, patch live slots on a write.
    // The tail slot is never live when a push happens (credit guarantees it).
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wptr == PW'(i))) begin
                r_ent_set[i]    <= r_req_set;
                r_ent_tag[i]    <= r_req_tag;
                r_ent_tags[i]   <= w_cap_tags;
                r_ent_states[i] <= w_cap_states;
                r_ent_evict[i]  <= w_cap_evict;
            end else if (w_ent_hit[i]) begin
                r_ent_tags[i]   <= put_tag(r_ent_tags[i], wr_way, wr_tag);
                r_ent_states[i] <= put_state(r_ent_states[i], wr_way, wr_state);
                if (wr_evict_en) begin
                    r_ent_evict[i] <= wr_evict_way;
                end else begin
                    r_ent_evict[i] <= r_ent_evict[i];
                end
            end else begin
                r_ent_tags[i]   <= r_ent_tags[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready     = w_req_ready;
    assign rd_en         = w_accept;
    assign rd_set        = w_accept ? req_set : {SET_BITS{1'b0}};
    assign out_valid     = w_out_valid;
    assign out_set       = r_ent_set[r_rptr];
    assign out_tag       = r_ent_tag[r_rptr];
    assign out_tags      = r_ent_tags[r_rptr];
    assign out_states    = r_ent_states[r_rptr];
    assign out_evict_way = r_ent_evict[r_rptr];

endmodule
